// File: rtl/result_array_serializer.sv
// Buffers 4-element result frames from the array-returning operation block and
// streams them out one element per transfer with index, op tag and last marker.
module result_array_serializer #(
    parameter int FRAME_DEPTH = 2,
    parameter int DATA_W      = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] result_array [0:3],
    input  logic              result_valid,
    input  logic [1:0]        op_select,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        out_index,
    output logic [1:0]        out_op,
    output logic              out_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [7:0]        drop_count
);

    localparam int PTR_W = (FRAME_DEPTH > 1) ? $clog2(FRAME_DEPTH) : 1;
    localparam int CNT_W = $clog2(FRAME_DEPTH + 1);

    typedef enum logic {
        S_EMPTY  = 1'b0,
        S_STREAM = 1'b1
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count;
    logic [1:0]         elem_idx;

    logic [DATA_W-1:0]  mem_data [FRAME_DEPTH][4];
    logic [1:0]         mem_op   [FRAME_DEPTH];

    logic               push;
    logic               drop;
    logic               xfer;
    logic               frame_done;

    function automatic logic [7:0] sat_inc8(input logic [7:0] val);
        return (val == 8'hFF) ? val : val + 8'd1;
    endfunction

    // Fullness is judged on pre-edge occupancy, so a frame arriving while full
    // is dropped even if the head frame completes on the same edge.
    assign in_ready   = (count != CNT_W'(FRAME_DEPTH));
    assign push       = result_valid && in_ready && rst_n;
    assign drop       = result_valid && !in_ready && rst_n;
    assign xfer       = out_valid && out_ready;
    assign frame_done = xfer && (elem_idx == 2'd3);

    // Frame storage carries data only and is deliberately left unreset.
    always_ff @(posedge clk) begin
        if (push) begin
            for (int e = 0; e < 4; e++) begin
                mem_data[wr_ptr][e] <= result_array[e];
            end
            mem_op[wr_ptr] <= op_select;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            elem_idx   <= 2'd0;
            drop_count <= 8'd0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (xfer) begin
                elem_idx <= elem_idx + 2'd1;
            end
            if (frame_done) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, frame_done})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            if (drop) begin
                drop_count <= sat_inc8(drop_count);
            end
        end
    end

    // Read-side state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_EMPTY;
        end else begin
            state <= state_next;
        end
    end

    // Leaves STREAM only when the last buffered frame finishes with no refill.
    always_comb begin
        state_next = state;
        case (state)
            S_EMPTY: begin
                if (push) begin
                    state_next = S_STREAM;
                end
            end
            S_STREAM: begin
                if (frame_done && !push && (count == CNT_W'(1))) begin
                    state_next = S_EMPTY;
                end
            end
            default: state_next = S_EMPTY;
        endcase
    end

    always_comb begin
        out_valid = 1'b0;
        out_data  = '0;
        out_index = 2'd0;
        out_op    = 2'd0;
        out_last  = 1'b0;
        if (state == S_STREAM) begin
            out_valid = 1'b1;
            out_data  = mem_data[rd_ptr][elem_idx];
            out_index = elem_idx;
            out_op    = mem_op[rd_ptr];
            out_last  = (elem_idx == 2'd3);
        end
    end

endmodule

// File: tb/tb_result_array_serializer.sv
// Directed and randomized bench for result_array_serializer against a frame-queue model.
module tb_result_array_serializer;

    localparam int DEPTH = 2;

    logic       clk;
    logic       rst_n;
    logic [7:0] result_array [0:3];
    logic       result_valid;
    logic [1:0] op_select;
    logic       in_ready;
    logic [7:0] out_data;
    logic [1:0] out_index;
    logic [1:0] out_op;
    logic       out_last;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] drop_count;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed {
        logic [3:0][7:0] d;
        logic [1:0]      op;
    } frame_t;

    frame_t q[$];
    int     m_idx   = 0;
    int     m_drops = 0;
    int     m_xfers = 0;

    result_array_serializer #(.FRAME_DEPTH(DEPTH), .DATA_W(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .result_array (result_array),
        .result_valid (result_valid),
        .op_select    (op_select),
        .in_ready     (in_ready),
        .out_data     (out_data),
        .out_index    (out_index),
        .out_op       (out_op),
        .out_last     (out_last),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .drop_count   (drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        logic [31:0] e_valid, e_data, e_idx, e_op, e_last;
        e_valid = (q.size() != 0) ? 32'd1 : 32'd0;
        e_data  = 0;
        e_idx   = 0;
        e_op    = 0;
        e_last  = 0;
        if (q.size() != 0) begin
            e_data = 32'(q[0].d[m_idx]);
            e_idx  = 32'(m_idx);
            e_op   = 32'(q[0].op);
            e_last = (m_idx == 3) ? 32'd1 : 32'd0;
        end
        chk({tag, ".valid"}, 32'(out_valid), e_valid);
        chk({tag, ".data"},  32'(out_data),  e_data);
        chk({tag, ".index"}, 32'(out_index), e_idx);
        chk({tag, ".op"},    32'(out_op),    e_op);
        chk({tag, ".last"},  32'(out_last),  e_last);
        chk({tag, ".in_ready"}, 32'(in_ready), (q.size() < DEPTH) ? 32'd1 : 32'd0);
        chk({tag, ".drops"}, 32'(drop_count), 32'(m_drops));
    endtask

    // Check current outputs, advance the model by one edge using the driven inputs.
    task automatic tick(input string tag);
        frame_t f;
        bit     full;
        check_all(tag);
        full = (q.size() == DEPTH);
        if (q.size() != 0 && out_ready) begin
            m_xfers++;
            if (m_idx == 3) begin
                m_idx = 0;
                void'(q.pop_front());
            end else begin
                m_idx++;
            end
        end
        if (result_valid) begin
            if (full) begin
                if (m_drops < 255) m_drops++;
            end else begin
                for (int i = 0; i < 4; i++) f.d[i] = result_array[i];
                f.op = op_select;
                q.push_back(f);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_frame(input logic [1:0] op, input logic [31:0] bytes_be);
        op_select       = op;
        result_array[0] = bytes_be[31:24];
        result_array[1] = bytes_be[23:16];
        result_array[2] = bytes_be[15:8];
        result_array[3] = bytes_be[7:0];
    endtask

    task automatic pulse(input string tag, input logic [1:0] op, input logic [31:0] bytes_be);
        set_frame(op, bytes_be);
        result_valid = 1'b1;
        tick(tag);
        result_valid = 1'b0;
    endtask

    task automatic idle(input string tag, input int n);
        for (int i = 0; i < n; i++) tick(tag);
    endtask

    initial begin
        rst_n        = 1'b0;
        result_valid = 1'b0;
        out_ready    = 1'b0;
        set_frame(2'd0, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        rst_n = 1'b1;

        // Basic frame, ready high
        out_ready = 1'b1;
        pulse("f0", 2'b00, 32'h0B0C0D0E);
        chk("f0.first_data", 32'(out_data), 32'h0B);
        idle("f0", 6);

        // Stall for 5 cycles on element 0
        out_ready = 1'b0;
        pulse("stall", 2'b10, 32'h5AA0AF5A);
        idle("stall", 5);
        chk("stall.hold_data", 32'(out_data), 32'h5A);
        chk("stall.hold_op", 32'(out_op), 32'h2);
        out_ready = 1'b1;
        idle("stall_rel", 6);

        // Overflow with 3 pulses, ready low
        out_ready = 1'b0;
        pulse("ovf1", 2'b01, 32'h11223344);
        idle("ovf", 29);
        pulse("ovf2", 2'b10, 32'h55667788);
        chk("ovf.in_ready_low", 32'(in_ready), 32'd0);
        idle("ovf", 29);
        pulse("ovf3", 2'b11, 32'h99AABBCC);
        chk("ovf.drop_one", 32'(drop_count), 32'd1);
        m_xfers = 0;
        out_ready = 1'b1;
        idle("ovf_drain", 12);
        chk("ovf.xfer_count", 32'(m_xfers), 32'd8);

        // Back-to-back pulses every 4 cycles, ready high
        for (int k = 0; k < 8; k++) begin
            pulse("b2b", 2'(k), $urandom);
            idle("b2b", 3);
        end
        chk("b2b.no_new_drops", 32'(drop_count), 32'd1);
        idle("b2b_drain", 8);

        // Saturate drop counter
        out_ready = 1'b0;
        for (int k = 0; k < 300; k++) pulse("sat", 2'(k), $urandom);
        chk("sat.ff", 32'(drop_count), 32'hFF);

        // Reset mid-frame after element 1 transfers
        rst_n = 1'b0;
        #1;
        q.delete(); m_idx = 0; m_drops = 0;
        rst_n = 1'b1;
        out_ready = 1'b1;
        pulse("mid", 2'b11, 32'h14280A00);
        idle("mid", 2);
        chk("mid.at_elem2", 32'(out_index), 32'd2);
        rst_n = 1'b0;
        #1;
        q.delete(); m_idx = 0; m_drops = 0;
        check_all("mid_rst");
        result_valid = 1'b1;
        @(posedge clk);
        #1;
        result_valid = 1'b0;
        check_all("mid_rst_hold");
        rst_n = 1'b1;
        idle("mid_rel", 2);
        pulse("mid_next", 2'b01, 32'hC1C2C3C4);
        chk("mid_next.idx0", 32'(out_index), 32'd0);
        idle("mid_next", 5);

        // Pointer wrap: 6 frames spaced 10 cycles
        for (int k = 0; k < 6; k++) begin
            pulse("wrap", 2'($urandom_range(0, 3)), $urandom);
            idle("wrap", 9);
        end

        // Randomized traffic
        for (int k = 0; k < 600; k++) begin
            out_ready    = ($urandom_range(0, 3) != 0);
            result_valid = ($urandom_range(0, 2) == 0);
            set_frame(2'($urandom_range(0, 3)), $urandom);
            tick("rand");
        end
        result_valid = 1'b0;
        out_ready    = 1'b1;
        idle("final", 12);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
